// File: rtl/seq_responder_pkg.sv
// Shared types and width helpers for the C / B..B / A sequence responder.
package seq_responder_pkg;

  // Recogniser and response states. The detectors use IDLE/GOT_C/GOT_B,
  // the response FSM in the top level uses IDLE/RESP_J/RESP_K.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GOT_C  = 3'd1,
    GOT_B  = 3'd2,
    RESP_J = 3'd3,
    RESP_K = 3'd4
  } seq_state_e;

  // Default parameter values and the counter widths they imply.
  localparam int DEF_MIN_B = 1;
  localparam int DEF_MAX_B = 3;
  localparam int DEF_J_LEN = 4;
  localparam int DEF_CNT_W = 8;
  localparam int B_CW      = $clog2(DEF_MAX_B + 1);
  localparam int J_CW      = $clog2(DEF_J_LEN + 1);

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_responder_if.sv
// Command / response bundle between the command driver, the responder and
// the J/K checks.
interface seq_responder_if #(
  parameter int CNT_W = 8
);
  logic             A;
  logic             B;
  logic             C;
  logic             X;
  logic             J;
  logic             K;
  logic             busy;
  logic             drop;
  logic             abort;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output A, B, C, X,
    input  J, K, busy, drop, abort, done_cnt
  );

  modport slave (
    input  A, B, C, X,
    output J, K, busy, drop, abort, done_cnt
  );
endinterface

// File: rtl/seq_responder_detector.sv
// Recogniser for C, then MIN_B..MAX_B consecutive B, then A.
// o_match is a combinational flag for the cycle whose A completes the
// sequence; the recogniser returns to IDLE on that same edge.
module seq_detector
  import seq_responder_pkg::*;
#(
  parameter int MIN_B = 1,
  parameter int MAX_B = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_match,
  output logic o_active
);

  localparam int B_W = cnt_width(MAX_B);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [B_W-1:0]   r_b_cnt;
  logic [B_W-1:0]   w_b_cnt_next;

  // State and B-run counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_b_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_b_cnt <= w_b_cnt_next;
    end
  end

  // Next-state: A beats B beats C; a B run longer than MAX_B is a non-match.
  // The match flag is not gated by i_clr so a clear can coincide with the
  // final observation of a sequence.
  always_comb begin
    w_state_next = r_state;
    w_b_cnt_next = r_b_cnt;
    o_match      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_c) begin
          w_state_next = GOT_C;
        end
      end
      GOT_C: begin
        if (i_b) begin
          w_state_next = GOT_B;
          w_b_cnt_next = B_W'(1);
        end else if (i_c) begin
          w_state_next = GOT_C;
        end else begin
          w_state_next = IDLE;
        end
      end
      GOT_B: begin
        if (i_a && (r_b_cnt >= B_W'(MIN_B))) begin
          o_match      = 1'b1;
          w_state_next = IDLE;
          w_b_cnt_next = '0;
        end else if (i_b && (r_b_cnt < B_W'(MAX_B))) begin
          w_b_cnt_next = r_b_cnt + B_W'(1);
        end else if (i_c) begin
          w_state_next = GOT_C;
          w_b_cnt_next = '0;
        end else begin
          w_state_next = IDLE;
          w_b_cnt_next = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_b_cnt_next = '0;
      end
    endcase
    if (i_clr) begin
      w_state_next = IDLE;
      w_b_cnt_next = '0;
    end
  end

  assign o_active = (r_state != IDLE);

endmodule

// File: rtl/seq_responder.sv
// Sequence responder: on C, B{MIN_B..MAX_B}, A drives J for J_LEN cycles,
// then K for one cycle, and counts completed responses. A shadow recogniser
// watches the inputs during a response and flags ignored triggers on drop.
module seq_responder
  import seq_responder_pkg::*;
#(
  parameter int MIN_B = DEF_MIN_B,
  parameter int MAX_B = DEF_MAX_B,
  parameter int J_LEN = DEF_J_LEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           CLK,
  input  logic           RST,
  seq_responder_if.slave bus
);

  localparam int J_W = cnt_width(J_LEN);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [J_W-1:0]   r_j_cnt;
  logic [J_W-1:0]   w_j_cnt_next;
  logic [CNT_W-1:0] r_done_cnt;
  logic [CNT_W-1:0] w_done_cnt_next;
  logic             w_drop_next;
  logic             w_abort_next;
  logic             r_j;
  logic             r_k;
  logic             r_busy;
  logic             r_drop;
  logic             r_abort;

  logic             w_resp;
  logic             w_main_clr;
  logic             w_shadow_clr;
  logic             w_main_match;
  logic             w_main_active;
  logic             w_shadow_match;
  logic             w_shadow_active;

  assign w_resp = (r_state == RESP_J) || (r_state == RESP_K);

  // Main recogniser is frozen in IDLE while a response runs; the shadow one
  // only runs during a response and is flushed on the RESP_K edge so it
  // never carries into the next idle period.
  assign w_main_clr   = bus.X | w_resp;
  assign w_shadow_clr = bus.X | ~w_resp | (r_state == RESP_K);

  seq_detector #(
    .MIN_B (MIN_B),
    .MAX_B (MAX_B)
  ) u_main_det (
    .CLK      (CLK),
    .RST      (RST),
    .i_clr    (w_main_clr),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_c      (bus.C),
    .o_match  (w_main_match),
    .o_active (w_main_active)
  );

  seq_detector #(
    .MIN_B (MIN_B),
    .MAX_B (MAX_B)
  ) u_shadow_det (
    .CLK      (CLK),
    .RST      (RST),
    .i_clr    (w_shadow_clr),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_c      (bus.C),
    .o_match  (w_shadow_match),
    .o_active (w_shadow_active)
  );

  // Response FSM, pulse and counter registers; outputs follow the next state
  // so J rises on the edge that samples the terminating A.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_j_cnt    <= '0;
      r_done_cnt <= '0;
      r_j        <= 1'b0;
      r_k        <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_j_cnt    <= w_j_cnt_next;
      r_done_cnt <= w_done_cnt_next;
      r_j        <= (w_state_next == RESP_J);
      r_k        <= (w_state_next == RESP_K);
      r_busy     <= (w_state_next == RESP_J) || (w_state_next == RESP_K);
      r_drop     <= w_drop_next;
      r_abort    <= w_abort_next;
    end
  end

  // Next-state and pulse decode: X overrides everything; triggers seen
  // during a response are reported on drop and otherwise ignored.
  always_comb begin
    w_state_next    = r_state;
    w_j_cnt_next    = r_j_cnt;
    w_done_cnt_next = r_done_cnt;
    w_drop_next     = 1'b0;
    w_abort_next    = 1'b0;
    if (bus.X) begin
      w_state_next = IDLE;
      w_j_cnt_next = '0;
      w_abort_next = w_resp | w_main_active | w_shadow_active;
    end else begin
      case (r_state)
        RESP_J: begin
          w_drop_next = w_shadow_match;
          if (r_j_cnt == J_W'(J_LEN)) begin
            w_state_next = RESP_K;
            w_j_cnt_next = '0;
          end else begin
            w_j_cnt_next = r_j_cnt + J_W'(1);
          end
        end
        RESP_K: begin
          w_drop_next     = w_shadow_match;
          w_state_next    = IDLE;
          w_done_cnt_next = r_done_cnt + CNT_W'(1);
        end
        default: begin
          if (w_main_match) begin
            w_state_next = RESP_J;
            w_j_cnt_next = J_W'(1);
          end else begin
            w_state_next = IDLE;
          end
        end
      endcase
    end
  end

  assign bus.J        = r_j;
  assign bus.K        = r_k;
  assign bus.busy     = r_busy;
  assign bus.drop     = r_drop;
  assign bus.abort    = r_abort;
  assign bus.done_cnt = r_done_cnt;

endmodule

// File: tb/tb_seq_responder.sv
// Bench for seq_responder: directed scenarios plus a randomized run, all
// checked against a pattern-matching model of the command stream.
module tb_seq_responder;

  localparam int MIN_B = 1;
  localparam int MAX_B = 3;
  localparam int J_LEN = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  seq_responder_if #(.CNT_W(8)) bus ();
  seq_responder_if #(.CNT_W(2)) bus_s ();

  assign bus_s.A = bus.A;
  assign bus_s.B = bus.B;
  assign bus_s.C = bus.C;
  assign bus_s.X = bus.X;

  seq_responder #(.MIN_B(MIN_B), .MAX_B(MAX_B), .J_LEN(J_LEN), .CNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  seq_responder #(.MIN_B(MIN_B), .MAX_B(MAX_B), .J_LEN(J_LEN), .CNT_W(2)) dut_s (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: symbol histories since the last clear; a trigger is a
  // history ending in C B^n A with MIN_B <= n <= MAX_B.
  byte mh[$];
  byte sh[$];
  int  pos = 0;     // 0 idle, 1..J_LEN J cycle index, J_LEN+1 K cycle
  int  m_done = 0;
  bit  e_drop = 1'b0;
  bit  e_abort = 1'b0;
  int  obs_j, obs_k, obs_drop, obs_abort;

  function automatic bit ends_match(input byte q[$]);
    int n;
    int k;
    n = q.size();
    k = 0;
    if (n < 2) return 1'b0;
    if (q[n-1] != "A") return 1'b0;
    while ((n - 2 - k) >= 0 && q[n-2-k] == "B") k++;
    if ((n - 2 - k) < 0) return 1'b0;
    return (q[n-2-k] == "C") && (k >= MIN_B) && (k <= MAX_B);
  endfunction

  function automatic bit ends_open(input byte q[$]);
    int n;
    int k;
    n = q.size();
    k = 0;
    if (n < 1) return 1'b0;
    while ((n - 1 - k) >= 0 && q[n-1-k] == "B") k++;
    if ((n - 1 - k) < 0) return 1'b0;
    return (q[n-1-k] == "C") && (k <= MAX_B);
  endfunction

  task automatic model_step(input byte s, input bit rst);
    e_drop  = 1'b0;
    e_abort = 1'b0;
    if (rst) begin
      pos = 0; m_done = 0; mh.delete(); sh.delete();
    end else if (s == "X") begin
      e_abort = (pos != 0) || ends_open(mh);
      pos = 0; mh.delete(); sh.delete();
    end else if (pos == 0) begin
      mh.push_back(s);
      if (mh.size() > MAX_B + 3) void'(mh.pop_front());
      if (ends_match(mh)) begin
        pos = 1; mh.delete(); sh.delete();
      end
    end else begin
      sh.push_back(s);
      if (sh.size() > MAX_B + 3) void'(sh.pop_front());
      if (ends_match(sh)) begin
        e_drop = 1'b1; sh.delete();
      end
      if (pos == J_LEN + 1) begin
        pos = 0; m_done++; sh.delete();
      end else begin
        pos++;
      end
    end
  endtask

  function automatic bit exp_j(); return (pos >= 1) && (pos <= J_LEN); endfunction
  function automatic bit exp_k(); return pos == J_LEN + 1; endfunction

  // One clock: drive a symbol, let the edge sample it, observe at +1.
  task automatic cyc(input byte s);
    bus.A = (s == "A");
    bus.B = (s == "B");
    bus.C = (s == "C");
    bus.X = (s == "X");
    @(posedge CLK);
    model_step(s, RST);
    #1;
    obs_j     += int'(bus.J);
    obs_k     += int'(bus.K);
    obs_drop  += int'(bus.drop);
    obs_abort += int'(bus.abort);
  endtask

  task automatic run_seq(input string s);
    for (int i = 0; i < s.len(); i++) cyc(s[i]);
  endtask

  task automatic clr_obs();
    obs_j = 0; obs_k = 0; obs_drop = 0; obs_abort = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    run_seq("CBA");
    n_cmp++; if (bus.J !== 1'b0) begin n_bad++; $display("FAIL reset_J got %b want 0", bus.J); end
    n_cmp++; if (bus.K !== 1'b0) begin n_bad++; $display("FAIL reset_K got %b want 0", bus.K); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop got %b want 0", bus.drop); end
    n_cmp++; if (bus.abort !== 1'b0) begin n_bad++; $display("FAIL reset_abort got %b want 0", bus.abort); end
    n_cmp++; if (bus.done_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_done got %0d want 0", bus.done_cnt); end
    RST = 1'b0;
    run_seq("--");
    $display("test_reset: done");
  endtask

  task automatic test_single();
    clr_obs();
    run_seq("CBA");
    n_cmp++; if (bus.J !== 1'b1) begin n_bad++; $display("FAIL single_J_rise got %b want 1", bus.J); end
    for (int i = 0; i < 7; i++) begin
      cyc("-");
      n_cmp++; if (bus.J !== exp_j() || bus.K !== exp_k()) begin
        n_bad++; $display("FAIL single_JK cyc%0d got J=%b K=%b want J=%b K=%b", i, bus.J, bus.K, exp_j(), exp_k());
      end
    end
    n_cmp++; if (obs_j != J_LEN || obs_k != 1) begin n_bad++; $display("FAIL single_len got J=%0d K=%0d want J=%0d K=1", obs_j, obs_k, J_LEN); end
    n_cmp++; if (bus.done_cnt !== 8'd1) begin n_bad++; $display("FAIL single_done got %0d want 1", bus.done_cnt); end
    n_cmp++; if (obs_drop != 0 || obs_abort != 0) begin n_bad++; $display("FAIL single_pulses got drop=%0d abort=%0d want 0 0", obs_drop, obs_abort); end
    $display("test_single: J cycles %0d K cycles %0d", obs_j, obs_k);
  endtask

  task automatic test_max_b();
    logic [7:0] d0;
    d0 = bus.done_cnt;
    clr_obs();
    run_seq("CBBBA------");
    n_cmp++; if (obs_j != J_LEN || obs_k != 1) begin n_bad++; $display("FAIL maxb_ok got J=%0d K=%0d want J=%0d K=1", obs_j, obs_k, J_LEN); end
    clr_obs();
    run_seq("CBBBBA------");
    n_cmp++; if (obs_j != 0 || obs_k != 0) begin n_bad++; $display("FAIL maxb_over got J=%0d K=%0d want 0 0", obs_j, obs_k); end
    n_cmp++; if (bus.done_cnt !== d0 + 8'd1) begin n_bad++; $display("FAIL maxb_done got %0d want %0d", bus.done_cnt, d0 + 8'd1); end
    $display("test_max_b: done_cnt %0d", bus.done_cnt);
  endtask

  task automatic test_no_a();
    logic [7:0] d0;
    d0 = bus.done_cnt;
    clr_obs();
    run_seq("CBBB----X");
    n_cmp++; if (obs_j != 0 || obs_k != 0) begin n_bad++; $display("FAIL noa_resp got J=%0d K=%0d want 0 0", obs_j, obs_k); end
    n_cmp++; if (bus.abort !== 1'b0) begin n_bad++; $display("FAIL noa_idle_abort got %b want 0", bus.abort); end
    n_cmp++; if (bus.done_cnt !== d0) begin n_bad++; $display("FAIL noa_done got %0d want %0d", bus.done_cnt, d0); end
    run_seq("CX");
    n_cmp++; if (bus.abort !== 1'b1) begin n_bad++; $display("FAIL gotc_abort got %b want 1", bus.abort); end
    $display("test_no_a: done_cnt %0d", bus.done_cnt);
  endtask

  task automatic test_abort();
    logic [7:0] d0;
    d0 = bus.done_cnt;
    clr_obs();
    run_seq("CBA-X");
    n_cmp++; if (bus.J !== 1'b0 || bus.K !== 1'b0) begin n_bad++; $display("FAIL abort_JK got J=%b K=%b want 0 0", bus.J, bus.K); end
    n_cmp++; if (bus.abort !== 1'b1) begin n_bad++; $display("FAIL abort_pulse got %b want 1", bus.abort); end
    run_seq("------");
    n_cmp++; if (obs_k != 0 || obs_abort != 1 || obs_j != 2) begin
      n_bad++; $display("FAIL abort_counts got K=%0d abort=%0d J=%0d want 0 1 2", obs_k, obs_abort, obs_j);
    end
    n_cmp++; if (bus.done_cnt !== d0) begin n_bad++; $display("FAIL abort_done got %0d want %0d", bus.done_cnt, d0); end
    $display("test_abort: abort pulses %0d", obs_abort);
  endtask

  task automatic test_drop();
    logic [7:0] d0;
    d0 = bus.done_cnt;
    clr_obs();
    run_seq("CBACBA------");
    n_cmp++; if (obs_drop != 1) begin n_bad++; $display("FAIL drop_pulse got %0d want 1", obs_drop); end
    n_cmp++; if (obs_j != J_LEN || obs_k != 1) begin n_bad++; $display("FAIL drop_resp got J=%0d K=%0d want %0d 1", obs_j, obs_k, J_LEN); end
    n_cmp++; if (bus.done_cnt !== d0 + 8'd1) begin n_bad++; $display("FAIL drop_done got %0d want %0d", bus.done_cnt, d0 + 8'd1); end
    $display("test_drop: drop pulses %0d", obs_drop);
  endtask

  task automatic test_rst_mid();
    run_seq("CBA-");
    RST = 1'b1;
    cyc("-");
    n_cmp++; if ({bus.J, bus.K, bus.busy, bus.drop, bus.abort} !== 5'b0) begin
      n_bad++; $display("FAIL rstmid_out got %b want 00000", {bus.J, bus.K, bus.busy, bus.drop, bus.abort});
    end
    n_cmp++; if (bus.done_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid_done got %0d want 0", bus.done_cnt); end
    RST = 1'b0;
    run_seq("--");
    $display("test_rst_mid: done");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) run_seq("CBA-----");
    n_cmp++; if (bus_s.done_cnt !== 2'd1) begin n_bad++; $display("FAIL wrap_small got %0d want 1", bus_s.done_cnt); end
    n_cmp++; if (bus.done_cnt !== 8'd5) begin n_bad++; $display("FAIL wrap_big got %0d want 5", bus.done_cnt); end
    $display("test_wrap: small %0d big %0d", bus_s.done_cnt, bus.done_cnt);
  endtask

  task automatic test_random();
    byte s;
    int  r;
    int  bad0;
    bad0 = n_bad;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) s = "X";
      else if (r < 28) s = "A";
      else if (r < 60) s = "B";
      else if (r < 85) s = "C";
      else s = "-";
      RST = ($urandom_range(0, 299) == 0);
      cyc(s);
      n_cmp++; if ({bus.J, bus.K, bus.busy} !== {exp_j(), exp_k(), exp_j() | exp_k()}) begin
        n_bad++; $display("FAIL rnd_JKbusy cyc%0d got %b want %b", i, {bus.J, bus.K, bus.busy}, {exp_j(), exp_k(), exp_j() | exp_k()});
      end
      n_cmp++; if ({bus.drop, bus.abort} !== {e_drop, e_abort}) begin
        n_bad++; $display("FAIL rnd_pulses cyc%0d got %b want %b", i, {bus.drop, bus.abort}, {e_drop, e_abort});
      end
      n_cmp++; if (bus.done_cnt !== 8'(m_done)) begin
        n_bad++; $display("FAIL rnd_done cyc%0d got %0d want %0d", i, bus.done_cnt, 8'(m_done));
      end
      n_cmp++; if (bus_s.done_cnt !== 2'(m_done)) begin
        n_bad++; $display("FAIL rnd_done_small cyc%0d got %0d want %0d", i, bus_s.done_cnt, 2'(m_done));
      end
    end
    RST = 1'b0;
    $display("test_random: 3000 cycles, %0d completions, %0d new mismatches", m_done, n_bad - bad0);
  endtask

  initial begin
    bus.A = 1'b0; bus.B = 1'b0; bus.C = 1'b0; bus.X = 1'b0;
    clr_obs();
    test_reset();
    test_single();
    test_max_b();
    test_no_a();
    test_abort();
    test_drop();
    test_rst_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_responder.md
Name: seq_responder

Overview:
- Clocked responder that consumes the A/B/C/X command stream and produces the J/K response checked by the COMPLEX sequence property.
- Recognises C, then MIN_B..MAX_B consecutive B cycles, then A.
- On recognition it drives J high for J_LEN cycles, then K high for one cycle; X aborts everything.
- Sits directly downstream of the command driver and upstream of the J/K assertion checks.

Parameters:
- MIN_B, 1: minimum consecutive B cycles in the trigger sequence (must be >= 1).
- MAX_B, 3: maximum consecutive B cycles in the trigger sequence (must be >= MIN_B).
- J_LEN, 4: number of consecutive J-high cycles in the response (must be >= 1).
- CNT_W, 8: width of the completed-response counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- A  input  1  command A (terminates the trigger).
- B  input  1  command B (repeat element).
- C  input  1  command C (starts the trigger).
- X  input  1  abort / disable.
- J  output  1  response J, registered.
- K  output  1  response K, registered.
- busy  output  1  high while J or K is being driven.
- drop  output  1  one-cycle pulse: a complete trigger was seen while busy and was ignored.
- abort  output  1  one-cycle pulse: X sampled high while not in IDLE.
- done_cnt  output  CNT_W  count of completed J..K responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (RST high at a posedge):
  - state = IDLE; b_cnt and j_cnt cleared.
  - J, K, busy, drop, abort, done_cnt all 0.
  - RST has priority over every other input, including mid-response.
- Timing: inputs change after a posedge and are sampled at the next posedge.
  - J rises at the same posedge that samples the terminating A.
  - It is therefore visible at the negedge following the A cycle, which satisfies the `|=>` of the property.
- States: IDLE, GOT_C, GOT_B, RESP_J, RESP_K.
- Detection priority per cycle, after RST: X, then A, then B, then C.
- X high (not RST):
  - next state IDLE; counters cleared; J = K = busy = 0.
  - abort = 1 if the current state != IDLE.
  - done_cnt unchanged.
- IDLE:
  - C -> GOT_C.
  - Otherwise stay in IDLE; A and B alone are ignored.
- GOT_C:
  - B -> GOT_B with b_cnt = 1.
  - else C -> GOT_C (restart).
  - else -> IDLE.
- GOT_B:
  - A and b_cnt >= MIN_B -> RESP_J with j_cnt = 1 and J = 1.
  - else B and b_cnt < MAX_B -> b_cnt + 1.
  - else C -> GOT_C.
  - else -> IDLE.
  - B when b_cnt == MAX_B is treated as a non-match: go to GOT_C if C is also high, else IDLE.
- RESP_J:
  - J = 1, busy = 1.
  - If j_cnt == J_LEN: next state RESP_K with J = 0, K = 1. Otherwise j_cnt + 1.
- RESP_K:
  - K = 1, busy = 1 for exactly one cycle.
  - Then IDLE with J = K = 0, and done_cnt increments by 1 on that transition.
- Response in progress:
  - A shadow detector (same IDLE/GOT_C/GOT_B rules) keeps tracking inputs during RESP_J/RESP_K.
  - A completed shadow match pulses drop for one cycle and resets the shadow to IDLE.
  - A response is never restarted or extended.
  - The shadow detector does not carry over: the main detector begins in IDLE after RESP_K.
- Output invariants:
  - J and K are never high simultaneously.
  - busy = J | K.
  - drop and abort are single-cycle pulses.
- done_cnt wrap: at 2^CNT_W - 1, the next completion yields 0.

Decomposition:
- Package seq_responder_pkg holds:
  - state enum seq_state_e {IDLE, GOT_C, GOT_B, RESP_J, RESP_K};
  - localparam helper widths: B_CW = $clog2(MAX_B+1), J_CW = $clog2(J_LEN+1).
- One sub-module, seq_detector:
  - the IDLE/GOT_C/GOT_B recogniser with a `match` output;
  - instantiated twice: main detector and shadow detector.
- The top level holds the response counter FSM, pulse generation and done_cnt.

Test Plan:
- Stimulus C;B;A;J... -> J high for exactly 4 cycles starting the cycle after A, K high 1 cycle, done_cnt 0->1, no drop/abort.
- Stimulus C;B;B;B;A -> same 4J+1K response; stimulus C;B;B;B;B;A -> no response, J stays 0.
- Stimulus C;B;B;B (no A) -> J/K remain 0, state returns to IDLE, done_cnt unchanged.
- Stimulus C;B;A, then X on the 2nd J cycle -> J drops the next cycle, K never asserted, abort pulses once, done_cnt unchanged.
- Stimulus C;B;A followed by C;B;A during the J phase -> single 4J+1K response, drop pulses once, done_cnt +1 only.
- RST mid-RESP_J -> all outputs 0 the next cycle; CNT_W=2 with 5 completions -> done_cnt reads 1.
